// File: rtl/rst_seq_cpu.sv
// Reset sequencer on the CPU PLL clock. After lock it releases resets in order:
// CPU, then peripherals, then OV5640 PWDN, then OV5640 RESETB.
module rst_seq_cpu #(
  parameter int unsigned LOCK_STABLE_CYC = 1000,
  parameter int unsigned PERIPH_DLY_CYC  = 100,
  parameter int unsigned CAM_PWDN_CYC    = 50000,
  parameter int unsigned CAM_RST_CYC     = 100000,
  parameter int unsigned SOFT_RST_CYC    = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pll_lock,
  input  logic soft_rst_req,
  output logic cpu_rst_n,
  output logic periph_rst_n,
  output logic cam_pwdn,
  output logic cam_rst_n,
  output logic seq_done
);

  localparam logic [23:0] LOCK_N   = 24'(LOCK_STABLE_CYC - 1);
  localparam logic [23:0] PERIPH_N = 24'(PERIPH_DLY_CYC - 1);
  localparam logic [23:0] PWDN_N   = 24'(CAM_PWDN_CYC - 1);
  localparam logic [23:0] CRST_N   = 24'(CAM_RST_CYC - 1);
  localparam logic [23:0] SOFT_N   = 24'(SOFT_RST_CYC - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK, LOCK_STABLE, CPU_UP, PERIPH_UP, CAM_PWR, RUN, SOFT_HOLD
  } state_t;

  state_t      state, nxt;
  logic [23:0] cnt, cnt_nxt;
  logic        ff1, lock_s;
  logic [4:0]  outs_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ff1    <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      ff1    <= pll_lock;
      lock_s <= ff1;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt + 24'd1;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) nxt = LOCK_STABLE;
      end
      LOCK_STABLE: if (cnt == LOCK_N)   nxt = CPU_UP;
      CPU_UP:      if (cnt == PERIPH_N) nxt = PERIPH_UP;
      PERIPH_UP:   if (cnt == PWDN_N)   nxt = CAM_PWR;
      CAM_PWR:     if (cnt == CRST_N)   nxt = RUN;
      SOFT_HOLD:   if (cnt == SOFT_N)   nxt = CPU_UP;
      RUN: begin
        cnt_nxt = '0;
        if (soft_rst_req) nxt = SOFT_HOLD;
      end
      default: nxt = WAIT_LOCK;
    endcase
    // Lock loss overrides terminal counts and soft requests alike.
    if (!lock_s && state != WAIT_LOCK) nxt = WAIT_LOCK;
    if (nxt != state) cnt_nxt = '0;
  end

  // {cpu_rst_n, periph_rst_n, cam_pwdn, cam_rst_n, seq_done} for the next state.
  always_comb begin
    outs_nxt = 5'b00100;
    case (nxt)
      CPU_UP:    outs_nxt = 5'b10100;
      PERIPH_UP: outs_nxt = 5'b11100;
      CAM_PWR:   outs_nxt = 5'b11000;
      RUN:       outs_nxt = 5'b11011;
      default:   outs_nxt = 5'b00100;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      {cpu_rst_n, periph_rst_n, cam_pwdn, cam_rst_n, seq_done} <= 5'b00100;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      {cpu_rst_n, periph_rst_n, cam_pwdn, cam_rst_n, seq_done} <= outs_nxt;
    end
  end

endmodule

// File: tb/tb_rst_seq_cpu.sv
// Bench for rst_seq_cpu: directed scenarios plus random lock drops and soft
// requests, checked every cycle against a timeline model of the release order.
module tb_rst_seq_cpu;
  localparam int LOCK = 8, PER = 4, CAMP = 6, CAMR = 5, SOFT = 3;
  localparam int K_CPU = LOCK;
  localparam int K_PER = LOCK + PER;
  localparam int K_PWR = K_PER + CAMP;
  localparam int K_RUN = K_PWR + CAMR;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0, pll_lock = 1'b0, soft_rst_req = 1'b0;
  logic cpu_rst_n, periph_rst_n, cam_pwdn, cam_rst_n, seq_done;
  bit   clk_en = 1'b1;
  int   checks = 0, errors = 0;

  // Model: k = edges since LOCK_STABLE entry; active=0 means everything held.
  bit active;
  int k;
  bit h1, h2;

  rst_seq_cpu #(
    .LOCK_STABLE_CYC(LOCK), .PERIPH_DLY_CYC(PER), .CAM_PWDN_CYC(CAMP),
    .CAM_RST_CYC(CAMR), .SOFT_RST_CYC(SOFT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock),
    .soft_rst_req(soft_rst_req), .cpu_rst_n(cpu_rst_n),
    .periph_rst_n(periph_rst_n), .cam_pwdn(cam_pwdn),
    .cam_rst_n(cam_rst_n), .seq_done(seq_done)
  );

  always begin
    #5;
    if (clk_en) sys_clk = ~sys_clk;
  end

  function automatic logic [4:0] obs();
    return {cpu_rst_n, periph_rst_n, cam_pwdn, cam_rst_n, seq_done};
  endfunction

  function automatic logic [4:0] exp_out();
    if (!active) return 5'b00100;
    return {k >= K_CPU, k >= K_PER, k < K_PWR, k >= K_RUN, k >= K_RUN};
  endfunction

  task automatic model_reset();
    active = 1'b0; k = 0; h1 = 1'b0; h2 = 1'b0;
  endtask

  task automatic model_edge(input bit lk, input bit sf);
    bit seen;
    seen = h2;   // pll_lock as sampled two edges earlier
    h2 = h1;
    h1 = lk;
    if (active) begin
      if (!seen)                 active = 1'b0;
      else if (k >= K_RUN && sf) k = LOCK - SOFT;
      else if (k < K_RUN)        k++;
    end else if (seen) begin
      active = 1'b1;
      k = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Called just after a falling edge; drives inputs, clocks once, checks.
  task automatic cyc(input bit lk, input bit sf, input string tag);
    pll_lock = lk;
    soft_rst_req = sf;
    @(posedge sys_clk);
    model_edge(lk, sf);
    @(negedge sys_clk);
    soft_rst_req = 1'b0;
    chk(tag, obs(), exp_out());
  endtask

  initial begin
    bit lk;
    int low;
    model_reset();
    pll_lock = 1'b1;
    repeat (2) begin
      @(negedge sys_clk);
      chk("reset", obs(), 5'b00100);
    end
    sys_rst_n = 1'b1;

    // Power-up sequence with lock held
    repeat (30) cyc(1'b1, 1'b0, "s1_seq");
    chk("s1_run", obs(), 5'b11011);

    // Lock loss in RUN
    repeat (4) cyc(1'b0, 1'b0, "s3_loss");
    chk("s3_held", obs(), 5'b00100);

    // Relock, then brief drop so lock_s falls at LOCK_STABLE cnt=5
    for (int i = 0; i < 20 && !(active && k == 3); i++) cyc(1'b1, 1'b0, "s2_relock");
    chk("s2_reach", {4'b0, active && k == 3}, 5'b00001);
    repeat (3) cyc(1'b0, 1'b0, "s2_drop");
    repeat (30) cyc(1'b1, 1'b0, "s2_seq");
    chk("s2_run", obs(), 5'b11011);

    // Soft reset in RUN, then ignored pulse in PERIPH_UP
    cyc(1'b1, 1'b1, "s4_soft");
    chk("s4_s0", obs(), 5'b00100);
    repeat (8) cyc(1'b1, 1'b0, "s4_seq");
    chk("s4_periph", obs(), 5'b11100);
    cyc(1'b1, 1'b1, "s4_ignored");
    repeat (20) cyc(1'b1, 1'b0, "s4_seq2");
    chk("s4_run", obs(), 5'b11011);

    // Soft request and lock loss on the same edge
    cyc(1'b0, 1'b0, "s5_pre");
    cyc(1'b0, 1'b0, "s5_pre");
    cyc(1'b0, 1'b1, "s5_both");
    repeat (5) cyc(1'b0, 1'b0, "s5_low");
    chk("s5_held", obs(), 5'b00100);
    repeat (30) cyc(1'b1, 1'b0, "s5_seq");

    // Asynchronous reset mid CAM_PWR with the clock stopped
    cyc(1'b1, 1'b1, "s6_soft");
    for (int i = 0; i < 40 && k != K_PWR + 2; i++) cyc(1'b1, 1'b0, "s6_to_campwr");
    chk("s6_campwr", obs(), 5'b11000);
    clk_en = 1'b0;
    #3 sys_rst_n = 1'b0;
    #2 chk("s6_async", obs(), 5'b00100);
    model_reset();
    #20 sys_rst_n = 1'b1;
    #3 chk("s6_released", obs(), 5'b00100);
    clk_en = 1'b1;
    repeat (30) cyc(1'b1, 1'b0, "s6_seq");
    chk("s6_run", obs(), 5'b11011);

    // Random lock glitches and soft requests
    low = 0;
    for (int i = 0; i < 2000; i++) begin
      if (low > 0) begin
        lk = 1'b0;
        low--;
      end else if ($urandom_range(0, 59) == 0) begin
        lk = 1'b0;
        low = $urandom_range(0, 5);
      end else lk = 1'b1;
      cyc(lk, $urandom_range(0, 7) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
